// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the EXE stage. Owns HI/LO, stalls the
// pipeline through busy while an operation runs, and takes MTHI/MTLO writes.
//
// state | meaning
// IDLE  | waiting for mul_start/div_start; operands latched on start
// CALC  | one multiplier bit or one quotient bit per cycle, ITER cycles
// FIX   | sign correction and HI/LO commit
// DONE  | done pulse; pipeline advances; start inputs ignored
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mul_start,
  input  logic             div_start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_t             state;
  logic [4:0]         cnt;
  logic               op_div;
  logic               sign_res;
  logic               sign_a;
  // Multiply: multiplicand. Divide: divisor.
  logic [WIDTH-1:0]   opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   quot, rem;

  // Operand magnitudes for signed ops and one iteration step of each algorithm
  always_comb begin
    abs_a     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    abs_b     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    quot      = acc[WIDTH-1:0];
    rem       = acc[2*WIDTH-1:WIDTH];
  end

  // Stall request; already high in the issuing cycle
  always_comb begin
    busy = resetn & ((state == S_IDLE && (mul_start || div_start) && !flush) ||
                     state == S_CALC || state == S_FIX);
  end

  // Sequencer, datapath registers and HI/LO; the FIX commit is placed after
  // the MT writes so it wins when both land in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      sign_res <= 1'b0;
      sign_a   <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mthi_we) hi <= mt_data;
      if (mtlo_we) lo <= mt_data;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (mul_start || div_start) begin
              op_div   <= div_start;
              sign_res <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              sign_a   <= is_signed & src_a[WIDTH-1];
              opnd     <= div_start ? abs_b : abs_a;
              acc      <= {{WIDTH{1'b0}}, (div_start ? abs_a : abs_b)};
              cnt      <= '0;
              state    <= S_CALC;
            end
          end
          S_CALC: begin
            acc <= op_div ? div_next : mul_next;
            cnt <= cnt + 5'd1;
            if (cnt == LAST_CNT) state <= S_FIX;
          end
          S_FIX: begin
            if (!op_div) begin
              {hi, lo} <= sign_res ? -acc : acc;
            end else if (opnd != '0) begin
              lo <= sign_res ? -quot : quot;
              hi <= sign_a ? -rem : rem;
            end
            done  <= 1'b1;
            state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
